// File: rtl/bus68k_pkg.sv
// Shared 68030 bus encodings and the DMA bus-master state set.
package bus68k_pkg;

    // SIZ[1:0] transfer size
    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_3B   = 2'b11;

    // FC[2:0] function codes a DMA master may legally issue
    localparam logic [2:0] FC_USER_DATA = 3'b001;
    localparam logic [2:0] FC_USER_PROG = 3'b010;
    localparam logic [2:0] FC_SUPV_DATA = 3'b101;
    localparam logic [2:0] FC_SUPV_PROG = 3'b110;

    // Port size reported back to the requester
    localparam logic [1:0] PORT_32 = 2'b00;
    localparam logic [1:0] PORT_8  = 2'b01;
    localparam logic [1:0] PORT_16 = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_ACK, S_ADDR, S_STRB, S_WAIT, S_TERM, S_NEXT
    } state_e;

    // Active-low /DSACK[1:0] to port width; 11 never terminates, map it to 32-bit
    function automatic logic [1:0] dsack_port(input logic [1:0] ndsack);
        case (ndsack)
            2'b01:   return PORT_16;
            2'b10:   return PORT_8;
            default: return PORT_32;
        endcase
    endfunction

endpackage

// File: rtl/dma_busmaster_if.sv
// Local request/response handshake plus the 68030 bus pins of the DMA master.
interface dma_busmaster_if;
    logic        req_valid, req_ready, req_rnw;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_siz;
    logic [2:0]  req_fc;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_port;
    logic        nBR, nBG, nBGACK, nAS_in, nSTERM, nBERR;
    logic [1:0]  nDSACK;
    logic        bus_oe, data_oe, RnW_o, nAS_o, nDS_o;
    logic [31:0] ADDR_o, DATA_o, DATA_i;
    logic [2:0]  FC_o;
    logic [1:0]  SIZ_o;

    modport master (
        input  req_valid, req_addr, req_rnw, req_siz, req_fc, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_port, rsp_err,
        output nBR, nBGACK, bus_oe, data_oe, ADDR_o, FC_o, SIZ_o, RnW_o, nAS_o, nDS_o, DATA_o,
        input  nBG, nAS_in, nDSACK, nSTERM, nBERR, DATA_i
    );

    modport slave (
        output req_valid, req_addr, req_rnw, req_siz, req_fc, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_port, rsp_err,
        input  nBR, nBGACK, bus_oe, data_oe, ADDR_o, FC_o, SIZ_o, RnW_o, nAS_o, nDS_o, DATA_o,
        output nBG, nAS_in, nDSACK, nSTERM, nBERR, DATA_i
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous bus strobes; resets to a chosen idle level.
module sync2 #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q, sync_q;

    // metastability stage followed by the stable stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/dma_busmaster.sv
// 68030 bus initiator: arbitrates for the bus, runs one async cycle per local
// request, and reports data/port size/error back to the requester.
module dma_busmaster
    import bus68k_pkg::*;
#(
    parameter int TIMEOUT  = 128,
    parameter int HOLD_MAX = 8
) (
    input logic            DRAM_CLK,
    input logic            nRST,
    dma_busmaster_if.master bus
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = '1;
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

    state_e      state_q;
    logic        nbr_q, nbgack_q, nas_q, nds_q, rnw_q, bus_oe_q, data_oe_q;
    logic        req_ready_q, rsp_valid_q, rsp_err_q, nsterm_q;
    logic [1:0]  rsp_port_q, siz_q;
    logic [2:0]  fc_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [TW-1:0] tmo_q;
    logic [HW-1:0] ten_q;

    logic [4:0]  sync_s;
    logic        nbg_s, nas_s, nberr_s;
    logic [1:0]  ndsack_s;

    sync2 #(.W(5), .RST_VAL(5'h1F)) u_sync (
        .clk_i  (DRAM_CLK),
        .rst_ni (nRST),
        .d_i    ({bus.nBG, bus.nAS_in, bus.nBERR, bus.nDSACK}),
        .q_o    (sync_s)
    );
    assign {nbg_s, nas_s, nberr_s, ndsack_s} = sync_s;

    // /STERM is synchronous to the bus clock, so one sampling flop suffices
    always_ff @(posedge DRAM_CLK or negedge nRST) begin
        if (!nRST) nsterm_q <= 1'b1;
        else       nsterm_q <= bus.nSTERM;
    end

    logic          term_d, free_d, cont_d, cap_d;
    logic [1:0]    port_d;
    logic [TW-1:0] tmo_d;
    assign term_d = !nberr_s || !nsterm_q || (ndsack_s != 2'b11);
    assign port_d = !nsterm_q ? PORT_32 : dsack_port(ndsack_s);
    assign tmo_d  = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);
    assign free_d = !nbg_s && nas_s && (ndsack_s == 2'b11) && nsterm_q && nbgack_q;
    assign cont_d = bus.req_valid && (ten_q < HOLD_LIM) && !rsp_err_q;
    assign cap_d  = (state_q == S_ACK) || (state_q == S_NEXT && cont_d);

    // latch the request into the bus output registers as ADDR is entered
    always_ff @(posedge DRAM_CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q  <= '0;
            fc_q    <= '0;
            siz_q   <= '0;
            rnw_q   <= 1'b1;
            wdata_q <= '0;
        end else if (cap_d) begin
            addr_q  <= bus.req_addr;
            fc_q    <= bus.req_fc;
            siz_q   <= bus.req_siz;
            rnw_q   <= bus.req_rnw;
            wdata_q <= bus.req_wdata;
        end
    end

    // bus tenure / cycle sequencer with registered strobes
    always_ff @(posedge DRAM_CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            nbr_q       <= 1'b1;
            nbgack_q    <= 1'b1;
            nas_q       <= 1'b1;
            nds_q       <= 1'b1;
            bus_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_port_q  <= PORT_32;
            rdata_q     <= '0;
            tmo_q       <= '0;
            ten_q       <= '0;
        end else begin
            req_ready_q <= cap_d;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (bus.req_valid) begin
                    state_q <= S_ARB;
                    nbr_q   <= 1'b0;
                end
                S_ARB: if (free_d) begin
                    state_q  <= S_ACK;
                    nbgack_q <= 1'b0;
                    nbr_q    <= 1'b1;
                    bus_oe_q <= 1'b1;
                    ten_q    <= '0;
                end
                S_ACK: begin
                    state_q <= S_ADDR;
                    ten_q   <= ten_q + HW'(1);
                end
                S_ADDR: begin
                    state_q   <= S_STRB;
                    nas_q     <= 1'b0;
                    nds_q     <= !rnw_q;   // writes delay /DS one tick behind data
                    data_oe_q <= !rnw_q;
                    tmo_q     <= '0;
                end
                S_STRB: begin
                    state_q <= S_WAIT;
                    nds_q   <= 1'b0;
                    tmo_q   <= tmo_d;
                end
                S_WAIT: begin
                    tmo_q <= tmo_d;
                    if (term_d || tmo_q == TMO_LAST) begin
                        state_q     <= S_TERM;
                        nas_q       <= 1'b1;
                        nds_q       <= 1'b1;
                        data_oe_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= term_d ? !nberr_s : 1'b1;
                        rsp_port_q  <= term_d ? port_d : PORT_32;
                        if (term_d && rnw_q) rdata_q <= bus.DATA_i;
                    end
                end
                // the counter keeps running so a stuck slave cannot hold us here
                S_TERM: begin
                    tmo_q <= tmo_d;
                    if ((ndsack_s == 2'b11 && nberr_s) || tmo_q >= TMO_LAST)
                        state_q <= S_NEXT;
                end
                S_NEXT: if (cont_d) begin
                    state_q <= S_ADDR;
                    ten_q   <= ten_q + HW'(1);
                end else begin
                    state_q  <= S_IDLE;
                    bus_oe_q <= 1'b0;
                    nbgack_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_port  = rsp_port_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.nBR       = nbr_q;
    assign bus.nBGACK    = nbgack_q;
    assign bus.bus_oe    = bus_oe_q;
    assign bus.data_oe   = data_oe_q;
    assign bus.ADDR_o    = addr_q;
    assign bus.FC_o      = fc_q;
    assign bus.SIZ_o     = siz_q;
    assign bus.RnW_o     = rnw_q;
    assign bus.nAS_o     = nas_q;
    assign bus.nDS_o     = nds_q;
    assign bus.DATA_o    = wdata_q;
endmodule
